mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single block-wide `mem` port between two cache requesters, e.g. an I-side and a D-side `cache_data` instance.
- Accepts one block read or block write at a time from either requester.
- Drives `mem` for a fixed, programmable number of cycles, then returns read data and a one-cycle completion pulse to the granted requester.
- Round-robin fairness by default.

Parameters:
- PA_WIDTH, 32: physical address width.
- BLK_WIDTH, 512: block width in bits (64-byte block).
- OFF_BITS, 6: block offset bits; forced to zero on mem_addr.
- MEM_LAT, 2: cycles each mem access is held (legal range ≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request from requester 0 / 1; level, held until done.
- we0 / we1  in  1  1 = block write, 0 = block read.
- addr0 / addr1  in  PA_WIDTH  block address.
- wr_blk0 / wr_blk1  in  BLK_WIDTH  write data.
- done0 / done1  out  1  one-cycle completion pulse to requester 0 / 1.
- rsp_blk  out  BLK_WIDTH  read data of last completed read (shared by both requesters).
- busy  out  1  high while state ≠ IDLE.
- mem_addr  out  PA_WIDTH  to mem.addr.
- mem_rd_en  out  1  to mem.rd_en.
- mem_wr_en  out  1  to mem.wr_en.
- mem_wr_blk  out  BLK_WIDTH  to mem.wr_data.
- mem_rd_blk  in  BLK_WIDTH  from mem.rd_data.

Behaviour:
- Reset values (async, immediate):
  - state = IDLE; busy, done0/1, mem_rd_en, mem_wr_en = 0.
  - mem_addr, mem_wr_blk, rsp_blk = 0; cnt = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, XFER, DONE. All outputs are registered.
- IDLE:
  - Requests are sampled only in this state.
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both high: grant the requester ≠ last_grant.
  - On grant, in the same edge: latch gid and we_q; set mem_addr = addr with low OFF_BITS zeroed; mem_wr_blk = wr_blk (writes only; reads leave it unchanged).
  - On grant, also: mem_rd_en = ~we, mem_wr_en = we, cnt = MEM_LAT-1, last_grant = gid, go to XFER.
- XFER:
  - mem_addr, enables and mem_wr_blk are held stable.
  - cnt ≠ 0: decrement cnt.
  - cnt == 0: drop both enables; if read, rsp_blk ← mem_rd_blk; assert done[gid]; go to DONE.
  - Result: enables are high for exactly MEM_LAT cycles.
- DONE:
  - done[gid] is high for this one cycle only; return to IDLE.
  - rsp_blk is valid from the DONE cycle and holds until the next read completes; writes never change it.
- Requester rule: deassert req on the edge at which done is sampled high. A req still high in IDLE is a new request.
- Latency: req sampled at edge E → done high in cycle E+MEM_LAT+1. Back-to-back issue rate is one transaction per MEM_LAT+2 cycles.
- Boundary conditions:
  - req dropped during XFER: the transaction still completes and done still pulses.
  - addr or we changing during XFER: ignored, since values are latched.
  - mem_rd_en and mem_wr_en are never both 1.
  - rst_n asserted mid-XFER: enables drop immediately, no done is issued, state returns to IDLE.
  - Simultaneous requests under continuous contention: strict alternation 0,1,0,1…

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: on a tie, requester 0 always wins. last_grant is unused and may be optimised away.
- Not defined: round-robin as specified above.

Test Plan:
- Reset mid-XFER (rst_n low 25 ns, req0 read held) → all outputs 0 during reset; after release, first grant is 0; mem_rd_en high for exactly MEM_LAT=2 cycles.
- req0 read, addr0=0x0000_0047 → mem_addr=0x0000_0040; done0 pulses in cycle E+3; rsp_blk equals mem content at 0x40.
- req1 write, addr1=0x80, wr_blk1=512'hA5…A5, then req1 read 0x80 → mem_wr_en high 2 cycles; read returns rsp_blk=A5…A5; done0 never asserts.
- req0 and req1 both held for 4 transactions → grant order 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN, and requester 0 re-requesting immediately after each done0 (no idle cycle), order 0,0,0,0.
- Overlapping requests: req1 raised during requester 0's XFER, req0 dropped mid-XFER → done0 still pulses; req1 granted in the following IDLE; mem_rd_en/mem_wr_en never both high (assertion checked every cycle).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester handshakes, the shared read
// response and the block-wide memory port of mem_arbiter.
//   requester side : req0/1, we0/1, addr0/1, wr_blk0/1 -> arbiter
//                    done0/1, rsp_blk, busy            <- arbiter
//   memory side    : mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk <- arbiter
//                    mem_rd_blk                               -> arbiter
// Modports: slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 512
);
    logic                 req0;
    logic                 req1;
    logic                 we0;
    logic                 we1;
    logic [PA_WIDTH-1:0]  addr0;
    logic [PA_WIDTH-1:0]  addr1;
    logic [BLK_WIDTH-1:0] wr_blk0;
    logic [BLK_WIDTH-1:0] wr_blk1;
    logic                 done0;
    logic                 done1;
    logic [BLK_WIDTH-1:0] rsp_blk;
    logic                 busy;
    logic [PA_WIDTH-1:0]  mem_addr;
    logic                 mem_rd_en;
    logic                 mem_wr_en;
    logic [BLK_WIDTH-1:0] mem_wr_blk;
    logic [BLK_WIDTH-1:0] mem_rd_blk;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wr_blk0, wr_blk1, mem_rd_blk,
        output done0, done1, rsp_blk, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wr_blk0, wr_blk1, mem_rd_blk,
        input  done0, done1, rsp_blk, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide memory port between two cache requesters.
// One block read or write at a time; the memory enables are held for MEM_LAT
// cycles, then a one-cycle done pulse goes to the granted requester and read
// data is left on rsp_blk until the next read completes.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   arb    - mem_arbiter_if.slave (requester handshakes + memory port)
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN
//   defined     - on a tie requester 0 always wins
//   not defined - round-robin on ties (requester 0 wins the first tie)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | sample requests, grant one, launch the mem access
// S_XFER | mem enables held, counting down MEM_LAT cycles
// S_DONE | done pulse to the granted requester, return to idle
module mem_arbiter #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 512,
    parameter int OFF_BITS  = 6,
    parameter int MEM_LAT   = 2
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  arb
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t               r_state,      w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,        w_cnt_nxt;
    logic                 r_gid,        w_gid_nxt;
    logic                 r_we_q,       w_we_q_nxt;
    logic                 r_last_grant, w_last_grant_nxt;
    logic [PA_WIDTH-1:0]  r_mem_addr,   w_mem_addr_nxt;
    logic                 r_mem_rd_en,  w_mem_rd_en_nxt;
    logic                 r_mem_wr_en,  w_mem_wr_en_nxt;
    logic [BLK_WIDTH-1:0] r_mem_wr_blk, w_mem_wr_blk_nxt;
    logic [BLK_WIDTH-1:0] r_rsp_blk,    w_rsp_blk_nxt;
    logic                 r_done0,      w_done0_nxt;
    logic                 r_done1,      w_done1_nxt;
    logic                 r_busy,       w_busy_nxt;

    logic                 w_tie_gid;
    logic                 w_gid;
    logic                 w_sel_we;
    logic [PA_WIDTH-1:0]  w_sel_addr;
    logic [BLK_WIDTH-1:0] w_sel_blk;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_tie_gid = 1'b0;
`else
    assign w_tie_gid = ~r_last_grant;
`endif

    // Lone requester wins outright; a tie goes to the tie-break choice.
    assign w_gid      = (arb.req0 & arb.req1) ? w_tie_gid : arb.req1;
    assign w_sel_we   = w_gid ? arb.we1     : arb.we0;
    assign w_sel_addr = w_gid ? arb.addr1   : arb.addr0;
    assign w_sel_blk  = w_gid ? arb.wr_blk1 : arb.wr_blk0;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_gid_nxt        = r_gid;
        w_we_q_nxt       = r_we_q;
        w_last_grant_nxt = r_last_grant;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_rd_en_nxt  = r_mem_rd_en;
        w_mem_wr_en_nxt  = r_mem_wr_en;
        w_mem_wr_blk_nxt = r_mem_wr_blk;
        w_rsp_blk_nxt    = r_rsp_blk;
        w_done0_nxt      = 1'b0;
        w_done1_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (arb.req0 | arb.req1) begin
                    w_gid_nxt        = w_gid;
                    w_we_q_nxt       = w_sel_we;
                    w_last_grant_nxt = w_gid;
                    w_mem_addr_nxt   = {w_sel_addr[PA_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                    if (w_sel_we) begin
                        w_mem_wr_blk_nxt = w_sel_blk;
                    end
                    w_mem_rd_en_nxt  = ~w_sel_we;
                    w_mem_wr_en_nxt  = w_sel_we;
                    w_cnt_nxt        = CNT_INIT;
                    w_state_nxt      = S_XFER;
                end
            end
            S_XFER: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_mem_rd_en_nxt = 1'b0;
                    w_mem_wr_en_nxt = 1'b0;
                    if (!r_we_q) begin
                        w_rsp_blk_nxt = arb.mem_rd_blk;
                    end
                    w_done0_nxt = ~r_gid;
                    w_done1_nxt = r_gid;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_gid        <= 1'b0;
            r_we_q       <= 1'b0;
            r_last_grant <= 1'b1;
            r_mem_addr   <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_wr_blk <= '0;
            r_rsp_blk    <= '0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gid        <= w_gid_nxt;
            r_we_q       <= w_we_q_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_rd_en  <= w_mem_rd_en_nxt;
            r_mem_wr_en  <= w_mem_wr_en_nxt;
            r_mem_wr_blk <= w_mem_wr_blk_nxt;
            r_rsp_blk    <= w_rsp_blk_nxt;
            r_done0      <= w_done0_nxt;
            r_done1      <= w_done1_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign arb.done0      = r_done0;
    assign arb.done1      = r_done1;
    assign arb.rsp_blk    = r_rsp_blk;
    assign arb.busy       = r_busy;
    assign arb.mem_addr   = r_mem_addr;
    assign arb.mem_rd_en  = r_mem_rd_en;
    assign arb.mem_wr_en  = r_mem_wr_en;
    assign arb.mem_wr_blk = r_mem_wr_blk;

endmodule
